decode_pipe: RTL and testbench

Registered, flow-controlled successor to the combinational decode stage. It accepts one instruction per cycle from fetch over a valid/ready handshake and extracts the RV32I fields, immediate and shift amount. It also detects illegal encodings and classifies the format. Results are presented to execute through a 2-entry (main + skid) output buffer, with flush support for branch redirects.

---
 rtl/decode_pipe.sv | 187 ++++++++++++++++++
 tb/tb_decode_pipe.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_pipe.sv
// RV32I decode stage with a valid/ready input, a registered main+skid output
// buffer and flush for branch redirects. Outputs always come from the main entry.
module decode_pipe #(
  parameter int DWIDTH  = 32,
  parameter int AWIDTH  = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DWIDTH-1:0] insn_i,
  input  logic [AWIDTH-1:0] pc_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [AWIDTH-1:0] pc_o,
  output logic [DWIDTH-1:0] insn_o,
  output logic [6:0]        opcode_o,
  output logic [4:0]        rd_o,
  output logic [4:0]        rs1_o,
  output logic [4:0]        rs2_o,
  output logic [2:0]        funct3_o,
  output logic [6:0]        funct7_o,
  output logic [4:0]        shamt_o,
  output logic [DWIDTH-1:0] imm_o,
  output logic [2:0]        fmt_o,
  output logic              illegal_o
);

  typedef struct packed {
    logic [AWIDTH-1:0] pc;
    logic [DWIDTH-1:0] insn;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [4:0]        shamt;
    logic [DWIDTH-1:0] imm;
    logic [2:0]        fmt;
    logic              illegal;
  } bundle_t;

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  logic [6:0] w_opc;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic       w_f7_ok;
  logic       w_illegal;
  bundle_t    w_raw;
  bundle_t    w_dec;

  assign w_opc   = insn_i[6:0];
  assign w_f3    = insn_i[14:12];
  assign w_f7    = insn_i[31:25];
  assign w_f7_ok = (w_f7 == 7'h00) || (w_f7 == 7'h20);

  always_comb begin
    w_raw     = '0;
    w_illegal = 1'b0;
    case (w_opc)
      7'b0110011: begin
        w_raw.fmt    = FMT_R;
        w_raw.rd     = insn_i[11:7];
        w_raw.rs1    = insn_i[19:15];
        w_raw.rs2    = insn_i[24:20];
        w_raw.funct3 = w_f3;
        w_raw.funct7 = w_f7;
        // Only ADD/SUB and SRL/SRA have an alternate (0100000) encoding.
        w_illegal    = !w_f7_ok || ((w_f7 == 7'h20) && (w_f3 != 3'b000) && (w_f3 != 3'b101));
      end
      7'b0010011, 7'b0000011, 7'b1100111: begin
        w_raw.fmt    = FMT_I;
        w_raw.rd     = insn_i[11:7];
        w_raw.rs1    = insn_i[19:15];
        w_raw.funct3 = w_f3;
        w_raw.imm    = {{20{insn_i[31]}}, insn_i[31:20]};
        if ((w_opc == 7'b0010011) && ((w_f3 == 3'b001) || (w_f3 == 3'b101))) begin
          w_raw.shamt  = insn_i[24:20];
          w_raw.funct7 = w_f7;
          w_illegal    = (w_f3 == 3'b001) ? (w_f7 != 7'h00) : !w_f7_ok;
        end
      end
      7'b0100011: begin
        w_raw.fmt    = FMT_S;
        w_raw.rs1    = insn_i[19:15];
        w_raw.rs2    = insn_i[24:20];
        w_raw.funct3 = w_f3;
        w_raw.imm    = {{20{insn_i[31]}}, insn_i[31:25], insn_i[11:7]};
      end
      7'b1100011: begin
        w_raw.fmt    = FMT_B;
        w_raw.rs1    = insn_i[19:15];
        w_raw.rs2    = insn_i[24:20];
        w_raw.funct3 = w_f3;
        w_raw.imm    = {{20{insn_i[31]}}, insn_i[7], insn_i[30:25], insn_i[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        w_raw.fmt = FMT_U;
        w_raw.rd  = insn_i[11:7];
        w_raw.imm = {insn_i[31:12], 12'h000};
      end
      7'b1101111: begin
        w_raw.fmt = FMT_J;
        w_raw.rd  = insn_i[11:7];
        w_raw.imm = {{12{insn_i[31]}}, insn_i[19:12], insn_i[20], insn_i[30:21], 1'b0};
      end
      default: w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_dec      = w_illegal ? bundle_t'('0) : w_raw;
    w_dec.pc   = pc_i;
    w_dec.insn = insn_i;
    if (w_illegal) begin
      w_dec.fmt     = FMT_ILL;
      w_dec.illegal = 1'b1;
    end
  end

  bundle_t r_main;
  bundle_t r_skid;
  logic    r_main_valid;
  logic    r_skid_valid;
  logic    w_accept;
  logic    w_xfer;

  // Ready depends only on buffer flops, never on out_ready_i.
  assign in_ready_o = SKID_EN ? !r_skid_valid : !r_main_valid;
  assign w_accept   = in_valid_i && in_ready_o && !flush_i;
  assign w_xfer     = r_main_valid && out_ready_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (flush_i) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_main_valid) begin
      if (w_accept) begin
        r_main       <= w_dec;
        r_main_valid <= 1'b1;
      end
    end else if (!SKID_EN) begin
      if (w_xfer) r_main_valid <= 1'b0;
    end else if (!r_skid_valid) begin
      if (w_accept && w_xfer) begin
        r_main <= w_dec;
      end else if (w_accept) begin
        r_skid       <= w_dec;
        r_skid_valid <= 1'b1;
      end else if (w_xfer) begin
        r_main_valid <= 1'b0;
      end
    end else if (w_xfer) begin
      r_main       <= r_skid;
      r_skid_valid <= 1'b0;
    end
  end

  assign out_valid_o = r_main_valid;
  assign pc_o        = r_main.pc;
  assign insn_o      = r_main.insn;
  assign opcode_o    = r_main.insn[6:0];
  assign rd_o        = r_main.rd;
  assign rs1_o       = r_main.rs1;
  assign rs2_o       = r_main.rs2;
  assign funct3_o    = r_main.funct3;
  assign funct7_o    = r_main.funct7;
  assign shamt_o     = r_main.shamt;
  assign imm_o       = r_main.imm;
  assign fmt_o       = r_main.fmt;
  assign illegal_o   = r_main.illegal;

endmodule

// File: tb/tb_decode_pipe.sv
// Randomized bench for decode_pipe: a queue-based scoreboard of accepted
// instructions, decoded by an arithmetic reference model, checked every cycle.
module tb_decode_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] insn_i;
  logic [31:0] pc_i;
  logic        flush_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] pc_o;
  logic [31:0] insn_o;
  logic [6:0]  opcode_o;
  logic [4:0]  rd_o;
  logic [4:0]  rs1_o;
  logic [4:0]  rs2_o;
  logic [2:0]  funct3_o;
  logic [6:0]  funct7_o;
  logic [4:0]  shamt_o;
  logic [31:0] imm_o;
  logic [2:0]  fmt_o;
  logic        illegal_o;

  decode_pipe #(.DWIDTH(32), .AWIDTH(32), .SKID_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .insn_i(insn_i), .pc_i(pc_i), .flush_i(flush_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .pc_o(pc_o), .insn_o(insn_o), .opcode_o(opcode_o),
    .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
    .funct3_o(funct3_o), .funct7_o(funct7_o), .shamt_o(shamt_o),
    .imm_o(imm_o), .fmt_o(fmt_o), .illegal_o(illegal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  rd, rs1, rs2, shamt;
    logic [2:0]  f3, fmt;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference decode: format from an opcode table, immediates as signed integers.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    int   fmt;
    logic bad;
    logic shift;
    logic [6:0] f7;
    logic [2:0] f3;
    f7 = ins[31:25];
    f3 = ins[14:12];
    case (ins[6:0])
      7'h33:               fmt = 0;
      7'h13, 7'h03, 7'h67: fmt = 1;
      7'h23:               fmt = 2;
      7'h63:               fmt = 3;
      7'h37, 7'h17:        fmt = 4;
      7'h6F:               fmt = 5;
      default:             fmt = 7;
    endcase
    shift = (ins[6:0] == 7'h13) && (f3 == 3'd1 || f3 == 3'd5);
    bad = 1'b0;
    if (fmt == 0) bad = !(f7 == 7'd0 || f7 == 7'd32) || (f7 == 7'd32 && !(f3 == 3'd0 || f3 == 3'd5));
    if (shift && f3 == 3'd1) bad = (f7 != 7'd0);
    if (shift && f3 == 3'd5) bad = !(f7 == 7'd0 || f7 == 7'd32);
    if (bad) fmt = 7;
    e.pc = pc; e.insn = ins;
    e.rd = 0; e.rs1 = 0; e.rs2 = 0; e.shamt = 0; e.f3 = 0; e.f7 = 0; e.imm = 0;
    e.fmt = 3'(fmt);
    e.ill = (fmt == 7);
    if (fmt == 0 || fmt == 1 || fmt == 4 || fmt == 5) e.rd = ins[11:7];
    if (fmt >= 0 && fmt <= 3) begin e.rs1 = ins[19:15]; e.f3 = f3; end
    if (fmt == 0 || fmt == 2 || fmt == 3) e.rs2 = ins[24:20];
    if (fmt == 0) e.f7 = f7;
    if (fmt == 1 && shift) begin e.f7 = f7; e.shamt = ins[24:20]; end
    case (fmt)
      1: e.imm = {20'd0, ins[31:20]} - (ins[31] ? 32'd4096 : 32'd0);
      2: e.imm = {20'd0, ins[31:25], ins[11:7]} - (ins[31] ? 32'd4096 : 32'd0);
      3: e.imm = {19'd0, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0} - (ins[31] ? 32'd8192 : 32'd0);
      4: e.imm = ins & 32'hFFFFF000;
      5: e.imm = {11'd0, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0} - (ins[31] ? 32'h200000 : 32'd0);
      default: e.imm = 0;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rand_insn();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 11))
      0: w[6:0] = 7'h33;  1: w[6:0] = 7'h13;  2: w[6:0] = 7'h03;
      3: w[6:0] = 7'h67;  4: w[6:0] = 7'h23;  5: w[6:0] = 7'h63;
      6: w[6:0] = 7'h37;  7: w[6:0] = 7'h17;  8: w[6:0] = 7'h6F;
      9: w[6:0] = 7'h13;
      default: ;
    endcase
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  task automatic check_outputs();
    exp_t e;
    chk("out_valid", out_valid_o, q.size() != 0);
    chk("in_ready", in_ready_o, q.size() < 2);
    if (out_valid_o && q.size() != 0) begin
      e = q[0];
      chk("pc", pc_o, e.pc);
      chk("insn", insn_o, e.insn);
      chk("opcode", opcode_o, e.insn[6:0]);
      chk("rd", rd_o, e.rd);
      chk("rs1", rs1_o, e.rs1);
      chk("rs2", rs2_o, e.rs2);
      chk("funct3", funct3_o, e.f3);
      chk("funct7", funct7_o, e.f7);
      chk("shamt", shamt_o, e.shamt);
      chk("imm", imm_o, e.imm);
      chk("fmt", fmt_o, e.fmt);
      chk("illegal", illegal_o, e.ill);
    end
  endtask

  // One clock: drive inputs just after a falling edge, update the scoreboard
  // at the rising edge, then check at the next falling edge.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic fl, input logic ordy);
    logic acc;
    logic xf;
    in_valid_i  = v;
    insn_i      = ins;
    pc_i        = pc;
    flush_i     = fl;
    out_ready_i = ordy;
    acc = v && in_ready_o && !fl;
    xf  = out_valid_o && ordy;
    @(posedge clk);
    if (xf && q.size() != 0) void'(q.pop_front());
    if (fl) q.delete();
    else if (acc) q.push_back(model(ins, pc));
    @(negedge clk);
    check_outputs();
    $display("cycle v=%0b insn=%08h pc=%08h flush=%0b ordy=%0b acc=%0b xfer=%0b depth=%0d",
             v, ins, pc, fl, ordy, acc, xf, q.size());
  endtask

  initial begin
    rst = 1'b0; in_valid_i = 1'b0; insn_i = '0; pc_i = '0; flush_i = 1'b0; out_ready_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid_o, 1'b0);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_imm", imm_o, 32'd0);
    chk("rst_fmt", fmt_o, 3'd0);
    rst = 1'b1;
    check_outputs();

    cycle(1'b1, 32'hFFF10093, 32'h100, 1'b0, 1'b1);
    chk("tp1_valid", out_valid_o, 1'b1);
    chk("tp1_rd", rd_o, 5'd1);
    chk("tp1_rs1", rs1_o, 5'd2);
    chk("tp1_imm", imm_o, 32'hFFFFFFFF);
    chk("tp1_fmt", fmt_o, 3'd1);
    cycle(1'b1, 32'h00509193, 32'h104, 1'b0, 1'b1);
    chk("slli_shamt", shamt_o, 5'd5);
    chk("slli_imm", imm_o, 32'd5);
    chk("slli_f3", funct3_o, 3'd1);
    cycle(1'b1, 32'hFFDFF0EF, 32'h108, 1'b0, 1'b1);
    chk("jal_imm", imm_o, 32'hFFFFFFFC);
    chk("jal_fmt", fmt_o, 3'd5);
    cycle(1'b1, 32'h0000000B, 32'h10C, 1'b0, 1'b1);
    chk("ill0_fmt", fmt_o, 3'd7);
    chk("ill0_illegal", illegal_o, 1'b1);
    cycle(1'b1, 32'h40001033, 32'h110, 1'b0, 1'b1);
    chk("ill1_illegal", illegal_o, 1'b1);
    chk("ill1_imm", imm_o, 32'd0);
    chk("ill1_rd", rd_o, 5'd0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Stall: three back-to-back, only two fit.
    cycle(1'b1, 32'h00100093, 32'h200, 1'b0, 1'b0);
    cycle(1'b1, 32'h00200113, 32'h204, 1'b0, 1'b0);
    cycle(1'b1, 32'h00300193, 32'h208, 1'b0, 1'b0);
    chk("stall_in_ready", in_ready_o, 1'b0);
    cycle(1'b1, 32'h00300193, 32'h208, 1'b0, 1'b1);
    chk("unstall_in_ready", in_ready_o, 1'b1);
    cycle(1'b1, 32'h00300193, 32'h208, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Flush while full, with an input offered in the same cycle.
    cycle(1'b1, 32'h00400213, 32'h300, 1'b0, 1'b0);
    cycle(1'b1, 32'h00500293, 32'h304, 1'b0, 1'b0);
    cycle(1'b1, 32'h00600313, 32'h308, 1'b1, 1'b0);
    chk("flush_valid", out_valid_o, 1'b0);
    chk("flush_ready", in_ready_o, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    cycle(1'b1, 32'h00700393, 32'h30C, 1'b0, 1'b1);

    for (int i = 0; i < 500; i++)
      cycle($urandom_range(0, 3) != 0, rand_insn(), $urandom, $urandom_range(0, 19) == 0,
            $urandom_range(0, 2) != 0);

    // Asynchronous reset mid-stream.
    cycle(1'b1, 32'h00800413, 32'h400, 1'b0, 1'b0);
    cycle(1'b1, 32'h00900493, 32'h404, 1'b0, 1'b0);
    in_valid_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", out_valid_o, 1'b0);
    chk("arst_pc", pc_o, 32'd0);
    chk("arst_imm", imm_o, 32'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    check_outputs();
    for (int i = 0; i < 100; i++)
      cycle($urandom_range(0, 1) != 0, rand_insn(), $urandom, 1'b0, $urandom_range(0, 1) != 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
